ram_lanes: RTL and testbench

Parametrised byte-lane data RAM that generalises the fixed 4×8-bit, 4096-word data memory into N lanes of configurable width and depth. It adds a hardware clear sweep after reset or on request, same-cycle write-to-read forwarding, and an out-of-range address error. It sits behind the core's load/store unit as data memory. Read data is registered with a one-cycle latency.

---
 rtl/ram_lanes.sv | 157 +++++++++++++++
 tb/tb_ram_lanes.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lanes.sv
// ram_lanes: byte-lane data RAM with per-lane write enables and registered
// read data. It clears itself with a one-word-per-cycle sweep after reset or
// on request, forwards same-cycle writes to reads, and flags out-of-range
// byte addresses.
//
// Handshake: there is no back-pressure. A request is accepted on any rising
// edge where busy_o is low. An accepted read returns r_data_o with r_valid_o
// for exactly one cycle after that edge. err_o pulses in the same cycle as the
// r_valid_o of that read, or one cycle after a rejected write. While busy_o is
// high, every request is dropped without a response.
module ram_lanes #(
    parameter int LANES          = 4,
    parameter int LANE_W         = 8,
    parameter int AW             = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic [LANES-1:0]          wen,
    input  logic [31:0]               w_addr_i,
    input  logic [LANES*LANE_W-1:0]   w_data_i,
    input  logic                      ren,
    input  logic [31:0]               r_addr_i,
    output logic [LANES*LANE_W-1:0]   r_data_o,
    output logic                      r_valid_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int DW       = LANES * LANE_W;
    localparam int DEPTH    = 1 << AW;
    localparam int ADDR_LSB = $clog2(DW / 8);
    localparam int ADDR_TOP = ADDR_LSB + AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   clr_idx_q;
    logic            busy_q;
    logic [DW-1:0]   r_data_q;
    logic            r_valid_q;
    logic            err_q;

    logic [DW-1:0]   mem [DEPTH];

    logic [AW-1:0]   w_idx;
    logic [AW-1:0]   r_idx;
    logic            w_oor;
    logic            r_oor;
    logic            accept;
    logic            wr_any;
    logic            wr_do;
    logic            rd_do;
    logic            same_word;
    logic [DW-1:0]   r_data_d;
    logic            err_d;

    // Decode addresses, range checks and the accept/forward qualifiers.
    always_comb begin
        w_idx     = w_addr_i[ADDR_LSB +: AW];
        r_idx     = r_addr_i[ADDR_LSB +: AW];
        // Any set bit above the word index puts the address past the array.
        w_oor     = (w_addr_i >> ADDR_TOP) != 32'd0;
        r_oor     = (r_addr_i >> ADDR_TOP) != 32'd0;
        accept    = (state_q == ST_IDLE);
        wr_any    = |wen;
        wr_do     = accept && wr_any && !w_oor;
        rd_do     = accept && ren;
        same_word = wr_do && (w_idx == r_idx);
        // A write error and a read error in the same cycle share one pulse.
        err_d     = accept && ((ren && r_oor) || (wr_any && w_oor));
    end

    // Next read word: stored data with freshly written lanes forwarded in.
    always_comb begin
        r_data_d = mem[r_idx];
        if (same_word) begin
            for (int k = 0; k < LANES; k++) begin
                if (wen[k]) begin
                    r_data_d[k*LANE_W +: LANE_W] = w_data_i[k*LANE_W +: LANE_W];
                end
            end
        end
        if (r_oor) begin
            r_data_d = '0;
        end
    end

    // Control FSM: zero sweep (CLEAR) and normal operation (IDLE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_idx_q <= '0;
            busy_q    <= CLEAR_ON_RESET;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_idx_q == {AW{1'b1}}) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear_i) begin
                        state_q   <= ST_CLEAR;
                        clr_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: sweep zeroes one word per cycle, otherwise per-lane writes.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_do) begin
            for (int k = 0; k < LANES; k++) begin
                if (wen[k]) begin
                    mem[w_idx][k*LANE_W +: LANE_W] <= w_data_i[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Registered read port and error pulse; read data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            r_valid_q <= rd_do;
            err_q     <= err_d;
            if (rd_do) begin
                r_data_q <= r_data_d;
            end
        end
    end

    assign r_data_o  = r_data_q;
    assign r_valid_o = r_valid_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_ram_lanes.sv
// tb_ram_lanes: directed tests for ram_lanes with default parameters.
module tb_ram_lanes;

    logic        clk;
    logic        rst;
    logic        clear_i;
    logic [3:0]  wen;
    logic [31:0] w_addr_i;
    logic [31:0] w_data_i;
    logic        ren;
    logic [31:0] r_addr_i;
    logic [31:0] r_data_o;
    logic        r_valid_o;
    logic        busy_o;
    logic        err_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    ram_lanes dut (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_i),
        .wen       (wen),
        .w_addr_i  (w_addr_i),
        .w_data_i  (w_data_i),
        .ren       (ren),
        .r_addr_i  (r_addr_i),
        .r_data_o  (r_data_o),
        .r_valid_o (r_valid_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i  = 1'b0;
        wen      = 4'b0000;
        ren      = 1'b0;
        w_addr_i = 32'h0;
        w_data_i = 32'h0;
        r_addr_i = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        w_addr_i = a;
        w_data_i = d;
        wen      = be;
        cyc();
        wen      = 4'b0000;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic v, output logic e);
        ren      = 1'b1;
        r_addr_i = a;
        cyc();
        d        = r_data_o;
        v        = r_valid_o;
        e        = err_o;
        ren      = 1'b0;
    endtask

    // Counts edges until busy_o falls, bounded so a stuck sweep still ends.
    task automatic wait_sweep(output int n);
        n = 0;
        while (busy_o && n < 5000) begin
            cyc();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic v, e;
        int n;
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        vec_cnt++;
        if (busy_o !== 1'b1 || r_valid_o !== 1'b0 || err_o !== 1'b0 || r_data_o !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_values: busy=%b valid=%b err=%b data=%h, want 1 0 0 00000000",
                     busy_o, r_valid_o, err_o, r_data_o);
        end
        rst = 1'b0;
        wait_sweep(n);
        vec_cnt++;
        if (n != 4096) begin
            err_cnt++;
            $display("FAIL reset_sweep_len: got %0d cycles, want 4096", n);
        end
        do_read(32'h3FFC, d, v, e);
        vec_cnt++;
        if (d !== 32'h0 || v !== 1'b1 || e !== 1'b0) begin
            err_cnt++;
            $display("FAIL read_after_sweep: data=%h valid=%b err=%b, want 00000000 1 0", d, v, e);
        end
        cyc();
        vec_cnt++;
        if (r_valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL valid_pulse_width: valid=%b, want 0", r_valid_o);
        end
    endtask

    task automatic test_byte_lane();
        logic [31:0] d;
        logic v, e;
        do_write(32'h100, 32'hDEADBEEF, 4'b1111);
        do_write(32'h100, 32'h000000AA, 4'b0001);
        do_read(32'h100, d, v, e);
        vec_cnt++;
        if (d !== 32'hDEADBEAA || v !== 1'b1) begin
            err_cnt++;
            $display("FAIL byte_lane0: data=%h valid=%b, want deadbeaa 1", d, v);
        end
        do_write(32'h100, 32'h00770000, 4'b0100);
        // low two address bits are ignored
        do_read(32'h103, d, v, e);
        vec_cnt++;
        if (d !== 32'hDE77BEAA) begin
            err_cnt++;
            $display("FAIL byte_lane2: data=%h, want de77beaa", d);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] d;
        logic v, e;
        do_write(32'h40, 32'h11223344, 4'b1111);
        w_addr_i = 32'h40;
        w_data_i = 32'hAABB0000;
        wen      = 4'b1100;
        do_read(32'h40, d, v, e);
        vec_cnt++;
        if (d !== 32'hAABB3344 || v !== 1'b1) begin
            err_cnt++;
            $display("FAIL forward_same_word: data=%h valid=%b, want aabb3344 1", d, v);
        end
        do_read(32'h40, d, v, e);
        vec_cnt++;
        if (d !== 32'hAABB3344) begin
            err_cnt++;
            $display("FAIL forward_committed: data=%h, want aabb3344", d);
        end
        // different words: read sees old contents of its own word
        do_write(32'h44, 32'h01020304, 4'b1111);
        w_addr_i = 32'h44;
        w_data_i = 32'h99999999;
        wen      = 4'b1111;
        do_read(32'h40, d, v, e);
        vec_cnt++;
        if (d !== 32'hAABB3344) begin
            err_cnt++;
            $display("FAIL rdw_diff_word: data=%h, want aabb3344", d);
        end
        do_read(32'h44, d, v, e);
        vec_cnt++;
        if (d !== 32'h99999999) begin
            err_cnt++;
            $display("FAIL rdw_diff_written: data=%h, want 99999999", d);
        end
    endtask

    task automatic test_range_error();
        logic [31:0] d;
        logic v, e;
        do_write(32'h4000, 32'h12345678, 4'b1111);
        vec_cnt++;
        if (err_o !== 1'b1 || r_valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL oor_write_err: err=%b valid=%b, want 1 0", err_o, r_valid_o);
        end
        cyc();
        vec_cnt++;
        if (err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL oor_err_pulse: err=%b, want 0", err_o);
        end
        do_read(32'h4000, d, v, e);
        vec_cnt++;
        if (d !== 32'h0 || v !== 1'b1 || e !== 1'b1) begin
            err_cnt++;
            $display("FAIL oor_read: data=%h valid=%b err=%b, want 00000000 1 1", d, v, e);
        end
        do_read(32'h0000, d, v, e);
        vec_cnt++;
        if (d !== 32'h0 || e !== 1'b0) begin
            err_cnt++;
            $display("FAIL oor_no_alias: data=%h err=%b, want 00000000 0", d, e);
        end
        // both ports out of range in one cycle: one pulse
        w_addr_i = 32'h8000_0000;
        w_data_i = 32'hFFFFFFFF;
        wen      = 4'b1111;
        do_read(32'h0001_0000, d, v, e);
        wen      = 4'b0000;
        cyc();
        vec_cnt++;
        if (e !== 1'b1 || err_o !== 1'b0 || d !== 32'h0) begin
            err_cnt++;
            $display("FAIL oor_dual: err=%b then %b data=%h, want 1 then 0, 00000000", e, err_o, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        addrs[0] = 32'h100; exps[0] = 32'hDE77BEAA;
        addrs[1] = 32'h40;  exps[1] = 32'hAABB3344;
        addrs[2] = 32'h44;  exps[2] = 32'h99999999;
        ren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_addr_i = addrs[i];
            cyc();
            vec_cnt++;
            if (r_data_o !== exps[i] || r_valid_o !== 1'b1) begin
                err_cnt++;
                $display("FAIL b2b_read%0d: data=%h valid=%b, want %h 1", i, r_data_o, r_valid_o, exps[i]);
            end
        end
        ren      = 1'b0;
        r_addr_i = 32'h100;
        cyc();
        vec_cnt++;
        if (r_data_o !== 32'h99999999 || r_valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_hold: data=%h valid=%b, want 99999999 0", r_data_o, r_valid_o);
        end
    endtask

    task automatic test_clear_busy();
        logic [31:0] d;
        logic v, e;
        int n;
        int bad;
        do_write(32'h8, 32'h00000055, 4'b1111);
        // clear_i with a read in the same cycle: read still served
        clear_i = 1'b1;
        do_read(32'h100, d, v, e);
        clear_i = 1'b0;
        vec_cnt++;
        if (busy_o !== 1'b1 || v !== 1'b1 || d !== 32'hDE77BEAA) begin
            err_cnt++;
            $display("FAIL clear_start: busy=%b valid=%b data=%h, want 1 1 de77beaa", busy_o, v, d);
        end
        n   = 0;
        bad = 0;
        while (busy_o && n < 5000) begin
            if (n >= 100 && n < 110) begin
                wen      = 4'b1111;
                w_addr_i = 32'h8;
                w_data_i = 32'hFFFFFFFF;
                ren      = 1'b1;
                r_addr_i = (n == 105) ? 32'h4000 : 32'h8;
                clear_i  = 1'b1;
            end else begin
                idle_inputs();
            end
            cyc();
            n++;
            if (r_valid_o !== 1'b0 || err_o !== 1'b0) bad++;
        end
        idle_inputs();
        vec_cnt++;
        if (n != 4096) begin
            err_cnt++;
            $display("FAIL clear_sweep_len: got %0d cycles, want 4096", n);
        end
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++;
            $display("FAIL busy_no_response: %0d cycles with valid/err, want 0", bad);
        end
        do_read(32'h8, d, v, e);
        vec_cnt++;
        if (d !== 32'h0 || v !== 1'b1) begin
            err_cnt++;
            $display("FAIL cleared_word: data=%h valid=%b, want 00000000 1", d, v);
        end
        do_read(32'h100, d, v, e);
        vec_cnt++;
        if (d !== 32'h0) begin
            err_cnt++;
            $display("FAIL cleared_word_100: data=%h, want 00000000", d);
        end
    endtask

    task automatic test_mid_sweep_reset();
        int n;
        do_write(32'h20, 32'hCAFEF00D, 4'b1111);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (1000) cyc();
        rst = 1'b1;
        cyc();
        vec_cnt++;
        if (busy_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_reset_busy: busy=%b, want 1", busy_o);
        end
        rst = 1'b0;
        wait_sweep(n);
        vec_cnt++;
        if (n != 4096) begin
            err_cnt++;
            $display("FAIL mid_reset_sweep_len: got %0d cycles, want 4096", n);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_byte_lane();
        test_forwarding();
        test_range_error();
        test_back_to_back();
        test_clear_busy();
        test_mid_sweep_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
